// File: rtl/gen_phase_pkg.sv
// Shared constants and types for the parametrised 4004-style phase sequencer.
package gen_phase_pkg;

  localparam int unsigned NUM_PHASES_4004 = 8;

  // Classic 4004 phase indices
  localparam int unsigned PH_A1 = 0;
  localparam int unsigned PH_A2 = 1;
  localparam int unsigned PH_A3 = 2;
  localparam int unsigned PH_M1 = 3;
  localparam int unsigned PH_M2 = 4;
  localparam int unsigned PH_X1 = 5;
  localparam int unsigned PH_X2 = 6;
  localparam int unsigned PH_X3 = 7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

  function automatic int unsigned phase_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/phase_prescaler.sv
// Divides CLK down to one phase tick every DIV enabled clocks; holds when EN=0.
module phase_prescaler #(
  parameter int unsigned DIV = 1
) (
  input  logic CLK,
  input  logic RES,
  input  logic CLR,
  input  logic EN,
  output logic TICK_C
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (RES || CLR) begin
      cnt_q <= '0;
    end else if (EN) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  assign TICK_C = (cnt_q == LAST);

endmodule

// File: rtl/gen_phase_seq.sv
// One-hot instruction-cycle phase ring with prescaler, wait-state stretch,
// run/freeze, single-cycle launch and a completed-cycle counter.
module gen_phase_seq
  import gen_phase_pkg::*;
#(
  parameter int unsigned NUM_PHASES    = NUM_PHASES_4004,
  parameter int unsigned SYNC_PHASE    = PH_A1,
  parameter int unsigned STRETCH_PHASE = PH_M1,
  parameter int unsigned DIV           = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                                CLK,
  input  logic                                RES,
  input  logic                                RUN,
  input  logic                                CONT,
  input  logic                                START,
  input  logic                                STALL,
  output logic [NUM_PHASES-1:0]               PHASE,
  output logic [phase_idx_w(NUM_PHASES)-1:0]  PHASE_IDX,
  output logic                                SYNC_N,
  output logic                                CYC_DONE,
  output logic [CNT_W-1:0]                    CYC_CNT,
  output logic                                ERR
);

  localparam int unsigned IDX_W   = phase_idx_w(NUM_PHASES);
  localparam int unsigned LAST_PH = NUM_PHASES - 1;
  localparam logic [NUM_PHASES-1:0] FIRST = NUM_PHASES'(1);

  seq_state_e              state_q, state_d;
  logic [NUM_PHASES-1:0]   phase_q, phase_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    err_q, err_d;

  logic presc_clr;
  logic presc_en;
  logic tick_c;
  logic stall_hit;
  logic adv;
  logic illegal;
  logic last_exit;

  // A stall only bites on the stretch phase; the prescaler parks at its
  // terminal count so the release clock advances immediately.
  assign stall_hit = STALL & phase_q[STRETCH_PHASE];
  assign presc_en  = RUN & ~(stall_hit & tick_c);
  assign adv       = RUN & tick_c & ~stall_hit;
  assign illegal   = (phase_q != '0) && !$onehot(phase_q);

  phase_prescaler #(
    .DIV (DIV)
  ) u_presc (
    .CLK    (CLK),
    .RES    (RES),
    .CLR    (presc_clr),
    .EN     (presc_en),
    .TICK_C (tick_c)
  );

  // Next-state for the ring, cycle counter and error flag
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    presc_clr = 1'b0;
    last_exit = 1'b0;

    case (state_q)
      ST_IDLE: begin
        presc_clr = 1'b1;
        if (RUN && (CONT || START)) begin
          state_d = ST_RUN;
          phase_d = FIRST;
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        if (adv) begin
          if (phase_q[LAST_PH]) begin
            last_exit = 1'b1;
            cnt_d     = cnt_q + CNT_W'(1);
            idx_d     = '0;
            if (CONT) begin
              phase_d = FIRST;
            end else begin
              state_d = ST_IDLE;
              phase_d = '0;
            end
          end else begin
            phase_d = {phase_q[NUM_PHASES-2:0], 1'b0};
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
        idx_d   = '0;
      end
    endcase

    // A corrupted ring restarts at phase 0 without counting the cycle
    if (illegal) begin
      state_d   = ST_RUN;
      phase_d   = FIRST;
      idx_d     = '0;
      cnt_d     = cnt_q;
      err_d     = 1'b1;
      presc_clr = 1'b1;
      last_exit = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign PHASE     = phase_q;
  assign PHASE_IDX = idx_q;
  assign CYC_CNT   = cnt_q;
  assign ERR       = err_q;
  assign CYC_DONE  = last_exit & ~RES;
  assign SYNC_N    = RES | ~(phase_d[SYNC_PHASE] & ~phase_q[SYNC_PHASE]);

endmodule

// File: tb/tb_gen_phase_seq.sv
// Directed bench for gen_phase_seq: DIV=1 and DIV=3 instances share stimulus and
// are checked every cycle against an integer-level model plus literal expectations.
module tb_gen_phase_seq;

  localparam int unsigned NP      = 8;
  localparam int unsigned SYNC_PH = 0;
  localparam int unsigned STR_PH  = 3;
  localparam int unsigned CW      = 16;

  logic CLK = 1'b0;
  logic RES, RUN, CONT, START, STALL;

  logic [NP-1:0] o_ph   [2];
  logic [2:0]    o_idx  [2];
  logic          o_syn  [2];
  logic          o_done [2];
  logic [CW-1:0] o_cnt  [2];
  logic          o_err  [2];

  int n_pass  = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  gen_phase_seq #(.DIV(1)) dut (
    .CLK(CLK), .RES(RES), .RUN(RUN), .CONT(CONT), .START(START), .STALL(STALL),
    .PHASE(o_ph[0]), .PHASE_IDX(o_idx[0]), .SYNC_N(o_syn[0]), .CYC_DONE(o_done[0]),
    .CYC_CNT(o_cnt[0]), .ERR(o_err[0])
  );

  gen_phase_seq #(.DIV(3)) dut3 (
    .CLK(CLK), .RES(RES), .RUN(RUN), .CONT(CONT), .START(START), .STALL(STALL),
    .PHASE(o_ph[1]), .PHASE_IDX(o_idx[1]), .SYNC_N(o_syn[1]), .CYC_DONE(o_done[1]),
    .CYC_CNT(o_cnt[1]), .ERR(o_err[1])
  );

  // Model state per instance: running flag, phase number, prescaler count
  int          m_div [2] = '{1, 3};
  bit          m_on  [2] = '{1'b1, 1'b1};
  bit          m_run [2] = '{1'b0, 1'b0};
  int          m_ph  [2] = '{0, 0};
  int          m_pre [2] = '{0, 0};
  bit [CW-1:0] m_cnt [2] = '{16'd0, 16'd0};
  bit          m_err [2] = '{1'b0, 1'b0};
  bit          e_done [2];
  bit          e_syn  [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Advance the model one clock using the inputs currently applied
  task automatic mdl_step(input int i);
    bit stalled, tick, adv, nrun;
    int nph;
    stalled   = m_run[i] && STALL && (m_ph[i] == int'(STR_PH));
    tick      = (m_pre[i] == m_div[i] - 1);
    adv       = m_run[i] && RUN && tick && !stalled;
    e_done[i] = !RES && adv && (m_ph[i] == int'(NP) - 1);
    if (RES) begin
      m_run[i] = 1'b0; m_ph[i] = 0; m_pre[i] = 0; m_cnt[i] = '0; m_err[i] = 1'b0;
      e_syn[i] = 1'b1;
      return;
    end
    nrun = m_run[i];
    nph  = m_ph[i];
    if (!m_run[i]) begin
      m_pre[i] = 0;
      if (RUN && (CONT || START)) begin nrun = 1'b1; nph = 0; end
    end else if (adv) begin
      m_pre[i] = 0;
      if (m_ph[i] == int'(NP) - 1) begin
        m_cnt[i] = m_cnt[i] + 1'b1;
        nph = 0;
        if (!CONT) nrun = 1'b0;
      end else begin
        nph = m_ph[i] + 1;
      end
    end else if (RUN && !tick) begin
      m_pre[i] = m_pre[i] + 1;
    end
    e_syn[i] = !(nrun && (nph == int'(SYNC_PH)) && !(m_run[i] && m_ph[i] == int'(SYNC_PH)));
    m_run[i] = nrun;
    m_ph[i]  = nph;
  endtask

  // Per-cycle comparison against the model
  initial begin
    @(posedge CLK);
    forever begin
      @(negedge CLK);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (m_on[i]) begin
          chk($sformatf("dut%0d PHASE", i), 32'(o_ph[i]), m_run[i] ? (32'(1) << m_ph[i]) : 32'(0));
          chk($sformatf("dut%0d PHASE_IDX", i), 32'(o_idx[i]), m_run[i] ? 32'(m_ph[i]) : 32'(0));
          chk($sformatf("dut%0d CYC_CNT", i), 32'(o_cnt[i]), 32'(m_cnt[i]));
          chk($sformatf("dut%0d ERR", i), 32'(o_err[i]), 32'(m_err[i]));
          mdl_step(i);
          chk($sformatf("dut%0d SYNC_N", i), 32'(o_syn[i]), 32'(e_syn[i]));
          chk($sformatf("dut%0d CYC_DONE", i), 32'(o_done[i]), 32'(e_done[i]));
        end
      end
    end
  end

  task automatic wait_ph(input int i, input logic [7:0] v, input int budget);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < budget && !hit; n++) begin
      @(negedge CLK);
      #3;
      hit = (o_ph[i] == v);
    end
    chk($sformatf("wait dut%0d PHASE=%0h", i, v), 32'(hit), 32'(1));
  endtask

  initial begin
    bit [CW-1:0] cnt_before;
    bit          hit;
    RES = 1'b1; RUN = 1'b1; CONT = 1'b1; START = 1'b0; STALL = 1'b0;

    // Reset values
    repeat (2) @(negedge CLK);
    #3;
    chk("rst PHASE", 32'(o_ph[0]), 32'h0);
    chk("rst CYC_CNT", 32'(o_cnt[0]), 32'h0);
    chk("rst SYNC_N", 32'(o_syn[0]), 32'h1);
    chk("rst ERR", 32'(o_err[0]), 32'h0);

    // Continuous ring, DIV=1 and DIV=3 side by side
    @(negedge CLK); RES = 1'b0;
    #3;
    chk("t1 SYNC_N first clk", 32'(o_syn[0]), 32'h0);
    chk("t1 still idle", 32'(o_ph[0]), 32'h0);
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      #3;
      chk("t1 ring", 32'(o_ph[0]), 32'(1) << k);
      chk("t2 div3 ring", 32'(o_ph[1]), 32'(1) << (k / 3));
      if (k == 7) begin
        chk("t1 SYNC_N at 0x80", 32'(o_syn[0]), 32'h0);
        chk("t1 CYC_DONE", 32'(o_done[0]), 32'h1);
      end
    end
    for (int k = 8; k <= 24; k++) begin
      @(negedge CLK);
      #3;
      if (k == 22) chk("t2 SYNC_N 2nd clk ph7", 32'(o_syn[1]), 32'h1);
      if (k == 23) begin
        chk("t2 PHASE 3rd clk ph7", 32'(o_ph[1]), 32'h80);
        chk("t2 SYNC_N 3rd clk ph7", 32'(o_syn[1]), 32'h0);
      end
    end
    chk("t1 CYC_CNT after 24", 32'(o_cnt[0]), 32'd3);
    chk("t1 wrap to 0x01", 32'(o_ph[0]), 32'h01);
    chk("t2 CYC_CNT after 24", 32'(o_cnt[1]), 32'd1);

    // Stall on the stretch phase
    wait_ph(0, 8'h04, 12);
    @(negedge CLK); STALL = 1'b1;
    #3;
    chk("t3 enter 0x08", 32'(o_ph[0]), 32'h08);
    for (int j = 1; j <= 5; j++) begin
      @(negedge CLK);
      if (j == 5) STALL = 1'b0;
      #3;
      chk("t3 held 0x08", 32'(o_ph[0]), 32'h08);
    end
    @(negedge CLK); STALL = 1'b1;
    #3;
    chk("t3 release to 0x10", 32'(o_ph[0]), 32'h10);
    @(negedge CLK); STALL = 1'b0;
    #3;
    chk("t3 stall off-phase no effect", 32'(o_ph[0]), 32'h20);

    // Single-cycle mode
    @(negedge CLK); CONT = 1'b0;
    wait_ph(0, 8'h00, 20);
    wait_ph(1, 8'h00, 40);
    cnt_before = m_cnt[0];
    repeat (3) begin
      @(negedge CLK);
      #3;
      chk("t4 idle holds", 32'(o_ph[0]), 32'h0);
    end
    @(negedge CLK); START = 1'b1;
    #3;
    chk("t4 idle during START", 32'(o_ph[0]), 32'h0);
    @(negedge CLK); START = 1'b0;
    #3;
    chk("t4 pass start", 32'(o_ph[0]), 32'h01);
    for (int k = 1; k < 8; k++) begin
      @(negedge CLK);
      START = (k == 2);
      #3;
      chk("t4 pass", 32'(o_ph[0]), 32'(1) << k);
    end
    @(negedge CLK); START = 1'b0;
    #3;
    chk("t4 back to idle", 32'(o_ph[0]), 32'h0);
    chk("t4 CYC_CNT +1", 32'(o_cnt[0]), 32'(cnt_before + 16'd1));
    repeat (4) begin
      @(negedge CLK);
      #3;
      chk("t4 no motion", 32'(o_ph[0]), 32'h0);
    end
    wait_ph(1, 8'h00, 40);

    // Freeze
    @(negedge CLK); CONT = 1'b1;
    wait_ph(0, 8'h02, 10);
    @(negedge CLK); RUN = 1'b0;
    #3;
    chk("t5 at 0x04", 32'(o_ph[0]), 32'h04);
    for (int j = 1; j <= 4; j++) begin
      @(negedge CLK);
      if (j == 4) RUN = 1'b1;
      #3;
      chk("t5 frozen 0x04", 32'(o_ph[0]), 32'h04);
      if (j == 2) chk("t5 SYNC_N frozen", 32'(o_syn[0]), 32'h1);
    end
    @(negedge CLK);
    #3;
    chk("t5 resume 0x08", 32'(o_ph[0]), 32'h08);

    // Illegal ring recovery, then mid-cycle reset
    @(negedge CLK); RES = 1'b1;
    @(negedge CLK); RES = 1'b0;
    wait_ph(0, 8'h04, 12);
    m_on[0] = 1'b0;
    force dut.phase_q = 8'h11;
    @(posedge CLK);
    #1;
    release dut.phase_q;
    hit = 1'b0;
    for (int n = 0; n < 3 && !hit; n++) begin
      @(negedge CLK);
      #3;
      hit = (o_ph[0] == 8'h01);
    end
    chk("t6 recover to 0x01", 32'(hit), 32'h1);
    chk("t6 ERR set", 32'(o_err[0]), 32'h1);
    chk("t6 PHASE_IDX", 32'(o_idx[0]), 32'h0);
    chk("t6 CYC_CNT", 32'(o_cnt[0]), 32'h0);
    m_run[0] = 1'b1; m_ph[0] = 0; m_pre[0] = 0; m_err[0] = 1'b1; m_cnt[0] = '0;
    mdl_step(0);
    m_on[0] = 1'b1;
    wait_ph(0, 8'h10, 10);
    chk("t6 ERR sticky", 32'(o_err[0]), 32'h1);
    @(negedge CLK); RES = 1'b1;
    #3;
    chk("t6 at 0x20", 32'(o_ph[0]), 32'h20);
    chk("t6 SYNC_N in RES", 32'(o_syn[0]), 32'h1);
    chk("t6 CYC_DONE in RES", 32'(o_done[0]), 32'h0);
    @(negedge CLK); RES = 1'b0;
    #3;
    chk("t6 PHASE after RES", 32'(o_ph[0]), 32'h0);
    chk("t6 CYC_CNT after RES", 32'(o_cnt[0]), 32'h0);
    chk("t6 ERR after RES", 32'(o_err[0]), 32'h0);
    repeat (10) @(negedge CLK);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
